// File: rtl/gap_scanner_pkg.sv
// Shared types for the gap scanner: FSM state encoding.
package gap_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gap_run_tracker.sv
// Run-length / best-run datapath for gap_scanner, stepped one bit per cycle.
// Position tracking only exists when GAP_SCANNER_POS_EN is defined.
module gap_run_tracker
    import gap_scanner_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic          bit_val,
    input  logic          polarity,
    input  logic [GW-1:0] idx,
    output logic [GW-1:0] best_len_next,
    output logic [GW-1:0] best_pos_next,
    output logic [GW-1:0] count_next
);

    logic [GW-1:0] run_r;
    logic [GW-1:0] run_next_s;
    logic          seen_r;
    logic          seen_next_s;
    logic [GW-1:0] best_len_r;
    logic [GW-1:0] count_r;
    logic          close_s;
    logic          better_s;

    // A run only closes on a bound bit after a bound has already been seen.
    assign close_s  = step && (bit_val != polarity) && seen_r && (run_r != '0);
    assign better_s = close_s && (run_r > best_len_r);

    // Next-state computation for run counter, seen-bound flag, best length and count
    always_comb begin
        run_next_s    = run_r;
        seen_next_s   = seen_r;
        best_len_next = best_len_r;
        count_next    = count_r;
        if (clear) begin
            run_next_s    = '0;
            seen_next_s   = 1'b0;
            best_len_next = '0;
            count_next    = '0;
        end else if (step) begin
            if (bit_val == polarity) begin
                if (seen_r) begin
                    run_next_s = run_r + GW'(1);
                end else begin
                    run_next_s = run_r;
                end
            end else begin
                seen_next_s = 1'b1;
                run_next_s  = '0;
                if (close_s) begin
                    count_next = count_r + GW'(1);
                end else begin
                    count_next = count_r;
                end
                if (better_s) begin
                    best_len_next = run_r;
                end else begin
                    best_len_next = best_len_r;
                end
            end
        end else begin
            run_next_s = run_r;
        end
    end

    // Tracker state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_r      <= '0;
            seen_r     <= 1'b0;
            best_len_r <= '0;
            count_r    <= '0;
        end else begin
            run_r      <= run_next_s;
            seen_r     <= seen_next_s;
            best_len_r <= best_len_next;
            count_r    <= count_next;
        end
    end

`ifdef GAP_SCANNER_POS_EN
    logic [GW-1:0] best_pos_r;

    // Best-run position: LSB index of the run that just closed
    always_comb begin
        best_pos_next = best_pos_r;
        if (clear) begin
            best_pos_next = '0;
        end else if (better_s) begin
            best_pos_next = idx - run_r;
        end else begin
            best_pos_next = best_pos_r;
        end
    end

    // Best-run position register
    always_ff @(posedge clk) begin
        if (rst) begin
            best_pos_r <= '0;
        end else begin
            best_pos_r <= best_pos_next;
        end
    end
`else
    logic unused_idx;
    assign unused_idx    = ^idx;
    assign best_pos_next = '0;
`endif

endmodule

// File: rtl/gap_scanner.sv
// Serial longest-bounded-run scanner, one bit per cycle, LSB first.
// Optional macro GAP_SCANNER_POS_EN enables gap_pos tracking.
module gap_scanner
    import gap_scanner_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           data,
    input  logic                       polarity,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   gap,
    output logic [$clog2(WIDTH)-1:0]   gap_pos,
    output logic [$clog2(WIDTH)-1:0]   gap_count
);

    localparam int GW = $clog2(WIDTH);

    state_t         state_r;
    state_t         state_next_s;
    logic [WIDTH-1:0] data_r;
    logic           polarity_r;
    logic [GW-1:0]  k_r;
    logic           clear_s;
    logic           step_s;
    logic           last_s;
    logic [GW-1:0]  len_next_s;
    logic [GW-1:0]  pos_next_s;
    logic [GW-1:0]  count_next_s;

    assign last_s = (k_r == GW'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = start ? SCAN : IDLE;
            SCAN:    state_next_s = last_s ? DONE : SCAN;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM control outputs to the datapath
    always_comb begin
        clear_s = 1'b0;
        step_s  = 1'b0;
        case (state_r)
            IDLE:    clear_s = start;
            SCAN:    step_s  = 1'b1;
            default: begin
                clear_s = 1'b0;
                step_s  = 1'b0;
            end
        endcase
    end

    // Operand capture and bit index
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r     <= '0;
            polarity_r <= 1'b0;
            k_r        <= '0;
        end else if (clear_s) begin
            data_r     <= data;
            polarity_r <= polarity;
            k_r        <= '0;
        end else if (step_s && !last_s) begin
            k_r <= k_r + GW'(1);
        end else begin
            k_r <= k_r;
        end
    end

    gap_run_tracker #(
        .WIDTH (WIDTH),
        .GW    (GW)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear_s),
        .step          (step_s),
        .bit_val       (data_r[k_r]),
        .polarity      (polarity_r),
        .idx           (k_r),
        .best_len_next (len_next_s),
        .best_pos_next (pos_next_s),
        .count_next    (count_next_s)
    );

    // Status and results; results load as the last bit is consumed so they are valid with done
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            gap       <= '0;
            gap_count <= '0;
        end else begin
            busy <= (state_next_s != IDLE);
            done <= (state_next_s == DONE);
            if (step_s && last_s) begin
                gap       <= len_next_s;
                gap_count <= count_next_s;
            end else begin
                gap       <= gap;
                gap_count <= gap_count;
            end
        end
    end

`ifdef GAP_SCANNER_POS_EN
    // Position result register
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_pos <= '0;
        end else if (step_s && last_s) begin
            gap_pos <= pos_next_s;
        end else begin
            gap_pos <= gap_pos;
        end
    end
`else
    logic unused_pos;
    assign unused_pos = ^pos_next_s;
    assign gap_pos    = '0;
`endif

endmodule

// File: tb/tb_gap_scanner.sv
// Self-checking bench for gap_scanner (WIDTH=16): vector table, scoreboard queue, corner sequences.
module tb_gap_scanner;

    localparam int WIDTH = 16;
    localparam int GW    = 4;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             p;
        logic [GW-1:0]    g;
        logic [GW-1:0]    gp;
        logic [GW-1:0]    gc;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic             polarity;
    logic             busy;
    logic             done;
    logic [GW-1:0]    gap;
    logic [GW-1:0]    gap_pos;
    logic [GW-1:0]    gap_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[9];
    vec_t sb[$];

    gap_scanner #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data      (data),
        .polarity  (polarity),
        .busy      (busy),
        .done      (done),
        .gap       (gap),
        .gap_pos   (gap_pos),
        .gap_count (gap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: segments strictly between consecutive bound bits.
    function automatic vec_t model(input logic [WIDTH-1:0] d, input logic p);
        vec_t r;
        int   last_b;
        r = '{d, p, 4'd0, 4'd0, 4'd0};
        last_b = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i] != p) begin
                if (last_b >= 0 && i - last_b > 1) begin
                    r.gc = r.gc + 4'd1;
                    if (i - last_b - 1 > int'(r.g)) begin
                        r.g  = GW'(i - last_b - 1);
                        r.gp = GW'(last_b + 1);
                    end
                end
                last_b = i;
            end
        end
        return r;
    endfunction

    function automatic vec_t adjust(input vec_t v);
        vec_t r;
        r = v;
`ifndef GAP_SCANNER_POS_EN
        r.gp = 4'd0;
`endif
        return r;
    endfunction

    // Start a scan, wait for done, compare against the scoreboard head.
    task automatic run_scan(input vec_t v, input string tag, input logic busy_poke);
        vec_t e;
        int   j;
        @(negedge clk);
        start    = 1'b1;
        data     = v.d;
        polarity = v.p;
        sb.push_back(adjust(v));
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy"}, busy, 1);
        j = 0;
        while (!done && j < 40) begin
            @(negedge clk);
            j++;
            if (busy_poke && j == 5) begin
                start    = 1'b1;
                data     = 16'hFFFF;
                polarity = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, j, WIDTH);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (done) begin
                check({tag, " gap"}, gap, e.g);
                check({tag, " gap_pos"}, gap_pos, e.gp);
                check({tag, " gap_count"}, gap_count, e.gc);
            end
        end
        @(negedge clk);
        check({tag, " done pulse"}, done, 0);
        check({tag, " hold"}, gap, e.g);
    endtask

    initial begin
        vec_t v;
        int   seen_done;

        vecs[0] = '{16'h8001, 1'b0, 4'd14, 4'd1,  4'd1};
        vecs[1] = '{16'h4225, 1'b0, 4'd4,  4'd10, 4'd4};
        vecs[2] = '{16'h1111, 1'b0, 4'd3,  4'd1,  4'd3};
        vecs[3] = '{16'h0000, 1'b0, 4'd0,  4'd0,  4'd0};
        vecs[4] = '{16'hFFFF, 1'b0, 4'd0,  4'd0,  4'd0};
        vecs[5] = '{16'h0F00, 1'b0, 4'd0,  4'd0,  4'd0};
        vecs[6] = '{16'hF000, 1'b0, 4'd0,  4'd0,  4'd0};
        vecs[7] = '{16'h5555, 1'b0, 4'd1,  4'd1,  4'd7};
        vecs[8] = '{16'h0FF0, 1'b1, 4'd8,  4'd4,  4'd1};

        rst = 1'b1; start = 1'b0; data = '0; polarity = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset gap", gap, 0);
        check("reset gap_count", gap_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_scan(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            v = model(16'($urandom), 1'($urandom_range(1)));
            run_scan(v, $sformatf("rnd%0d", i), 1'b0);
        end

        // start while busy is ignored
        run_scan(vecs[0], "busy_start", 1'b1);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("busy_start no 2nd done", seen_done, 0);
        check("busy_start result kept", gap, 14);

        // reset mid-scan
        @(negedge clk);
        start = 1'b1; data = 16'h8001; polarity = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst gap", gap, 0);
        check("midrst gap_pos", gap_pos, 0);
        check("midrst gap_count", gap_count, 0);
        seen_done = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check("midrst no done", seen_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
